// File: rtl/palette_regs.sv
// Palette register file: CPU-visible shadow copy plus an active copy that drives
// the pixel pipeline. The shadow is copied to the active copy only after a
// commit request has been seen and the next vblank start arrives. This keeps the
// displayed palette stable for a whole frame.
module palette_regs #(
   parameter int NUM_PAL     = 4,
   parameter int NUM_SLOT    = 8,
   parameter int IDX_W       = 6,
   parameter int VBLANK_LINE = 480,
   localparam int PAL_W      = (NUM_PAL  > 1) ? $clog2(NUM_PAL)  : 1,
   localparam int SLOT_W     = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1,
   localparam int WORD_W     = NUM_SLOT * IDX_W
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [9:0]                       line,
   input  logic [9:0]                       column,
   input  logic                             wr_valid,
   output logic                             wr_ready,
   input  logic [PAL_W-1:0]                 wr_pal,
   input  logic [SLOT_W-1:0]                wr_slot,
   input  logic [IDX_W-1:0]                 wr_data,
   input  logic                             rd_en,
   input  logic [PAL_W-1:0]                 rd_pal,
   input  logic [SLOT_W-1:0]                rd_slot,
   output logic                             rd_valid,
   output logic [IDX_W-1:0]                 rd_data,
   input  logic                             commit_req,
   output logic                             commit_pending,
   output logic                             commit_done,
   output logic [NUM_PAL-1:0][WORD_W-1:0]   palettes
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   state_t                                  state_r;
   state_t                                  next_state_s;

   logic [NUM_PAL-1:0][WORD_W-1:0]          shadow_r;
   logic [NUM_PAL-1:0][WORD_W-1:0]          active_r;

   logic                                    wr_ready_r;
   logic                                    rd_valid_r;
   logic [IDX_W-1:0]                        rd_data_r;
   logic                                    commit_pending_r;
   logic                                    commit_done_r;

   logic                                    vblank_start_s;
   logic                                    wr_accept_s;
   logic                                    copy_en_s;
   logic                                    wr_ready_nxt_s;
   logic                                    pending_nxt_s;
   logic                                    done_nxt_s;
   logic [NUM_PAL-1:0][NUM_SLOT-1:0]        wr_hit_s;
   logic [IDX_W-1:0]                        rd_word_s;

   // Commit point: first pixel of the first vblank line.
   always_comb begin
      vblank_start_s = (line == 10'(VBLANK_LINE)) && (column == 10'd0);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic. A request made during COMMIT re-arms immediately.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (commit_req) begin
               next_state_s = ST_PENDING;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_PENDING: begin
            if (vblank_start_s) begin
               next_state_s = ST_COMMIT;
            end else begin
               next_state_s = ST_PENDING;
            end
         end
         ST_COMMIT: begin
            if (commit_req) begin
               next_state_s = ST_PENDING;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // FSM output decode. Outputs are registered from the next state so they
   // line up with the state they describe. The copy happens while in COMMIT,
   // when writes are blocked and the shadow is frozen.
   always_comb begin
      wr_ready_nxt_s = 1'b1;
      pending_nxt_s  = 1'b0;
      done_nxt_s     = 1'b0;
      case (next_state_s)
         ST_IDLE: begin
            wr_ready_nxt_s = 1'b1;
         end
         ST_PENDING: begin
            pending_nxt_s  = 1'b1;
         end
         ST_COMMIT: begin
            wr_ready_nxt_s = 1'b0;
            done_nxt_s     = 1'b1;
         end
         default: begin
            wr_ready_nxt_s = 1'b0;
         end
      endcase
      copy_en_s   = (state_r == ST_COMMIT);
      wr_accept_s = wr_valid && wr_ready_r;
   end

   // Registered handshake/status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ready_r       <= 1'b0;
         commit_pending_r <= 1'b0;
         commit_done_r    <= 1'b0;
      end else begin
         wr_ready_r       <= wr_ready_nxt_s;
         commit_pending_r <= pending_nxt_s;
         commit_done_r    <= done_nxt_s;
      end
   end

   // Write decode. Out-of-range targets match no entry, so they are dropped.
   always_comb begin
      wr_hit_s = '0;
      for (int p = 0; p < NUM_PAL; p++) begin
         for (int s = 0; s < NUM_SLOT; s++) begin
            wr_hit_s[p][s] = wr_accept_s
                             && (wr_pal  == PAL_W'(p))
                             && (wr_slot == SLOT_W'(s));
         end
      end
   end

   // Read mux from the shadow. Out-of-range addresses read back as zero.
   always_comb begin
      rd_word_s = '0;
      for (int p = 0; p < NUM_PAL; p++) begin
         for (int s = 0; s < NUM_SLOT; s++) begin
            rd_word_s = rd_word_s
                        | ({IDX_W{(rd_pal == PAL_W'(p)) && (rd_slot == SLOT_W'(s))}}
                           & shadow_r[p][s*IDX_W +: IDX_W]);
         end
      end
   end

   // Shadow storage, written only through the CPU port.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow_r <= '0;
      end else begin
         for (int p = 0; p < NUM_PAL; p++) begin
            for (int s = 0; s < NUM_SLOT; s++) begin
               if (wr_hit_s[p][s]) begin
                  shadow_r[p][s*IDX_W +: IDX_W] <= wr_data;
               end
            end
         end
      end
   end

   // Read port: one-cycle latency. A same-cycle write is not visible yet.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_valid_r <= 1'b0;
         rd_data_r  <= '0;
      end else begin
         rd_valid_r <= rd_en;
         if (rd_en) begin
            rd_data_r <= rd_word_s;
         end
      end
   end

   // Active copy: updated in one shot on the commit cycle only.
   always_ff @(posedge clk) begin
      if (!reset) begin
         active_r <= '0;
      end else if (copy_en_s) begin
         active_r <= shadow_r;
      end
   end

   assign wr_ready       = wr_ready_r;
   assign rd_valid       = rd_valid_r;
   assign rd_data        = rd_data_r;
   assign commit_pending = commit_pending_r;
   assign commit_done    = commit_done_r;
   assign palettes       = active_r;

endmodule

// File: tb/tb_palette_regs.sv
// Bench for palette_regs: directed stimulus, a behavioural model of the
// shadow/active palettes checked every cycle, and hand-computed spot checks.
module tb_palette_regs;

   logic              clk = 1'b0;
   logic              reset;
   logic [9:0]        line;
   logic [9:0]        column;
   logic              wr_valid;
   logic              wr_ready;
   logic [1:0]        wr_pal;
   logic [2:0]        wr_slot;
   logic [5:0]        wr_data;
   logic              rd_en;
   logic [1:0]        rd_pal;
   logic [2:0]        rd_slot;
   logic              rd_valid;
   logic [5:0]        rd_data;
   logic              commit_req;
   logic              commit_pending;
   logic              commit_done;
   logic [3:0][47:0]  palettes;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int d0       = 0;

   always #5 clk = ~clk;

   palette_regs dut (
      .clk(clk), .reset(reset), .line(line), .column(column),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pal(wr_pal),
      .wr_slot(wr_slot), .wr_data(wr_data), .rd_en(rd_en),
      .rd_pal(rd_pal), .rd_slot(rd_slot), .rd_valid(rd_valid),
      .rd_data(rd_data), .commit_req(commit_req),
      .commit_pending(commit_pending), .commit_done(commit_done),
      .palettes(palettes)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: shadow/active arrays and a pending/commit flag.
   logic [5:0] sh [4][8];
   logic [5:0] ac [4][8];
   logic       m_ready, m_rv, m_pend, m_done;
   logic [5:0] m_rd;
   logic       started = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         for (int p = 0; p < 4; p++)
            for (int s = 0; s < 8; s++) begin
               sh[p][s] <= 6'd0;
               ac[p][s] <= 6'd0;
            end
         m_ready <= 1'b0; m_rv <= 1'b0; m_rd <= 6'd0;
         m_pend  <= 1'b0; m_done <= 1'b0; started <= 1'b1;
      end else begin
         m_rv <= rd_en;
         if (rd_en) m_rd <= sh[rd_pal][rd_slot];
         if (m_done)
            for (int p = 0; p < 4; p++)
               for (int s = 0; s < 8; s++)
                  ac[p][s] <= sh[p][s];
         if (wr_valid && m_ready) sh[wr_pal][wr_slot] <= wr_data;
         if (m_done) begin
            m_done <= 1'b0; m_pend <= commit_req; m_ready <= 1'b1;
         end else if (m_pend) begin
            if (line == 10'd480 && column == 10'd0) begin
               m_pend <= 1'b0; m_done <= 1'b1; m_ready <= 1'b0;
            end else begin
               m_ready <= 1'b1;
            end
         end else begin
            m_pend <= commit_req; m_ready <= 1'b1;
         end
      end
   end

   function automatic logic [47:0] model_word(input int p);
      logic [47:0] w;
      w = 48'd0;
      for (int s = 0; s < 8; s++) w[s*6 +: 6] = ac[p][s];
      return w;
   endfunction

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         check("wr_ready", 64'(wr_ready), 64'(m_ready));
         check("rd_valid", 64'(rd_valid), 64'(m_rv));
         check("rd_data", 64'(rd_data), 64'(m_rd));
         check("commit_pending", 64'(commit_pending), 64'(m_pend));
         check("commit_done", 64'(commit_done), 64'(m_done));
         for (int p = 0; p < 4; p++)
            check("palettes", 64'(palettes[p]), 64'(model_word(p)));
      end
      if (commit_done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; line = 10'd100; column = 10'd5;
      wr_valid = 1'b0; wr_pal = 2'd0; wr_slot = 3'd0; wr_data = 6'd0;
      rd_en = 1'b0; rd_pal = 2'd0; rd_slot = 3'd0; commit_req = 1'b0;
      tick(); tick();
      check("reset_wr_ready", 64'(wr_ready), 64'd0);
      check("reset_pending", 64'(commit_pending), 64'd0);
      check("reset_pal", 64'(palettes), 64'd0);
      reset = 1'b1;
      tick();
      check("idle_wr_ready", 64'(wr_ready), 64'd1);

      // 1: write p2 s5, commit at line 100, takes effect at vblank
      wr_valid = 1'b1; wr_pal = 2'd2; wr_slot = 3'd5; wr_data = 6'h21;
      tick();
      wr_valid = 1'b0; commit_req = 1'b1;
      tick();
      commit_req = 1'b0;
      check("t1_pending", 64'(commit_pending), 64'd1);
      tick(); tick(); tick();
      check("t1_pal_before", 64'(palettes[2]), 64'd0);
      line = 10'd480; column = 10'd0;
      tick();
      column = 10'd1;
      check("t1_done", 64'(commit_done), 64'd1);
      check("t1_pending_clr", 64'(commit_pending), 64'd0);
      tick();
      check("t1_pal_after", 64'(palettes[2][35:30]), 64'h21);
      check("t1_done_clr", 64'(commit_done), 64'd0);
      line = 10'd100; column = 10'd5;

      // 2: write then read back the shadow, no commit
      wr_valid = 1'b1; wr_pal = 2'd0; wr_slot = 3'd0; wr_data = 6'h3F;
      tick();
      wr_valid = 1'b0; rd_en = 1'b1; rd_pal = 2'd0; rd_slot = 3'd0;
      tick();
      rd_en = 1'b0;
      check("t2_rd_valid", 64'(rd_valid), 64'd1);
      check("t2_rd_data", 64'(rd_data), 64'h3F);
      check("t2_pal_untouched", 64'(palettes[0][5:0]), 64'd0);
      tick();
      check("t2_rd_valid_clr", 64'(rd_valid), 64'd0);

      // 3: write held across the commit cycle lands after the copy
      commit_req = 1'b1;
      tick();
      commit_req = 1'b0; line = 10'd480; column = 10'd0;
      tick();
      column = 10'd1;
      wr_valid = 1'b1; wr_pal = 2'd1; wr_slot = 3'd7; wr_data = 6'h15;
      check("t3_commit_ready", 64'(wr_ready), 64'd0);
      tick();
      check("t3_ready_after", 64'(wr_ready), 64'd1);
      check("t3_p0", 64'(palettes[0][5:0]), 64'h3F);
      tick();
      wr_valid = 1'b0; line = 10'd100; column = 10'd5;
      check("t3_p1_old", 64'(palettes[1][47:42]), 64'd0);
      wr_valid = 1'b1; wr_pal = 2'd3; wr_slot = 3'd0; wr_data = 6'h0A;
      tick();
      wr_valid = 1'b0;

      // 4: request on the vblank cycle itself waits a frame
      commit_req = 1'b1; line = 10'd480; column = 10'd0;
      tick();
      commit_req = 1'b0; column = 10'd1;
      check("t4_pending", 64'(commit_pending), 64'd1);
      check("t4_no_done", 64'(commit_done), 64'd0);
      line = 10'd100;
      tick();
      check("t4_p1_still_old", 64'(palettes[1][47:42]), 64'd0);
      line = 10'd480; column = 10'd0;
      tick();
      column = 10'd1;
      check("t4_done", 64'(commit_done), 64'd1);
      tick();
      check("t4_p1_new", 64'(palettes[1][47:42]), 64'h15);
      check("t4_p3_new", 64'(palettes[3][5:0]), 64'h0A);
      line = 10'd100; column = 10'd5;

      // 5: repeated requests give one commit; reset drops a pending commit
      d0 = done_cnt;
      commit_req = 1'b1; tick(); tick();
      commit_req = 1'b0; tick();
      commit_req = 1'b1; tick();
      commit_req = 1'b0;
      line = 10'd480; column = 10'd0; tick();
      column = 10'd1; tick(); tick();
      check("t5_single_done", 64'(done_cnt - d0), 64'd1);
      line = 10'd100; column = 10'd5;
      commit_req = 1'b1; tick();
      commit_req = 1'b0;
      check("t5_pending_set", 64'(commit_pending), 64'd1);
      reset = 1'b0; tick();
      reset = 1'b1;
      check("t5_pending_rst", 64'(commit_pending), 64'd0);
      check("t5_pal_rst", 64'(palettes), 64'd0);
      tick();
      line = 10'd480; column = 10'd0; tick();
      column = 10'd1;
      check("t5_no_done", 64'(commit_done), 64'd0);
      tick();
      check("t5_pal_still_zero", 64'(palettes), 64'd0);
      line = 10'd100; column = 10'd5;

      // 6: same-cycle read and write returns the old value
      wr_valid = 1'b1; wr_pal = 2'd3; wr_slot = 3'd3; wr_data = 6'h2A;
      rd_en = 1'b1; rd_pal = 2'd3; rd_slot = 3'd3;
      tick();
      wr_valid = 1'b0;
      check("t6_old", 64'(rd_data), 64'h00);
      check("t6_rv", 64'(rd_valid), 64'd1);
      tick();
      rd_en = 1'b0;
      check("t6_new", 64'(rd_data), 64'h2A);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
